// File: rtl/lfsr_fill_ctrl.sv
// lfsr_fill_ctrl: reseeds and steps an LFSR and writes each advanced word over valid/ready; define LFSR_FILL_CTRL_STALL_CNT_EN to count backpressure cycles
module lfsr_fill_ctrl #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             busy,
  output logic             done,
  output logic             lfsr_rst,
  output logic             en_addr,
  output logic             en_data,
  input  logic [9:0]       lfsr_addr,
  input  logic [31:0]      lfsr_data,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [9:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic [31:0]      stall_cycles
);
  typedef enum logic [2:0] {IDLE, SEED, STEP, WAIT1, LOAD, ISSUE, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, total, cnt_nxt;
  assign cnt_nxt = cnt + CNT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      total    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      lfsr_rst <= 1'b0;
      en_addr  <= 1'b0;
      en_data  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      done     <= state == DONE;
      lfsr_rst <= 1'b0;
      en_addr  <= 1'b0;
      en_data  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          total <= cfg_count;
          busy  <= 1'b1;
          state <= cfg_count == '0 ? DONE : SEED;
          lfsr_rst <= cfg_count != '0;
        end
        SEED: begin
          state   <= STEP;
          en_addr <= 1'b1;
          en_data <= 1'b1;
        end
        STEP:  state <= WAIT1;
        WAIT1: state <= LOAD;
        LOAD: begin
          wr_addr  <= lfsr_addr;
          wr_data  <= lfsr_data;
          wr_valid <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: if (wr_ready) begin
          wr_valid <= 1'b0;
          cnt      <= cnt_nxt;
          state    <= cnt_nxt == total ? DONE : STEP;
          en_addr  <= cnt_nxt != total;
          en_data  <= cnt_nxt != total;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef LFSR_FILL_CTRL_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) stall_q <= '0;
    else if (wr_valid && !wr_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule
